// File: rtl/instr_fetch_unit.sv
// Purpose : MIPS fetch front end. Owns the PC, issues word reads to a 1-cycle
//           synchronous imem, and queues the returned words in a 2-entry buffer
//           that feeds the control decoder.
// Latency : imem_req to if_valid is 2 cycles minimum. The head is driven from
//           queue registers, so there is no combinational path from imem_rdata.
// Backpr. : if_valid/id_ready handshake. When id_ready is low the queue fills
//           to 2 entries and requests stop. No instruction is lost or repeated.
// Ports   : clk, rst_n (async active-low); imem_req/imem_addr/imem_rdata
//           (instruction memory); if_valid/if_instr/if_opcode/if_pc with
//           id_ready (decode); redirect_valid/redirect_pc (branch resolution).
//           The optional stall_cycles output is present only when the macro
//           IFETCH_STALL_CNT_EN is defined.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [5:0]        if_opcode,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              id_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_run;          // low during reset so imem_req stays 0
  logic              r_inflight;
  logic              r_inflight_kill;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic [1:0]        r_count;
  logic [31:0]       r_instr0;       // entry 0 is the head
  logic [ADDR_W-1:0] r_pc0;
  logic [31:0]       r_instr1;
  logic [ADDR_W-1:0] r_pc1;

  logic              w_pop;
  logic              w_push;
  logic [2:0]        w_occ;
  logic [1:0]        w_slot;
  logic              w_req;
  logic              w_unused_redirect_lsb;

  assign w_pop  = (r_count != 2'd0) && id_ready;
  // The response to a request issued just before a redirect arrives in the
  // redirect cycle. The redirect term drops that response. The kill flag keeps
  // any late response from being accepted in the cycle after the redirect.
  assign w_push = r_inflight && !r_inflight_kill && !redirect_valid;
  // Occupancy after this cycle's pop, with the outstanding read counted. A pop
  // implies count >= 1, so the subtraction cannot underflow.
  assign w_occ  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_req  = r_run && !redirect_valid && (w_occ < 3'd2);
  // Tail slot the incoming word lands in, after the pop has shifted the queue.
  assign w_slot = r_count - {1'b0, w_pop};

  assign imem_req  = w_req;
  assign imem_addr = r_pc;
  assign if_valid  = (r_count != 2'd0);
  assign if_instr  = r_instr0;
  assign if_opcode = r_instr0[31:26];
  assign if_pc     = r_pc0;

  assign w_unused_redirect_lsb = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc            <= RESET_PC;
      r_run           <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_kill <= 1'b0;
      r_inflight_pc   <= '0;
      r_count         <= 2'd0;
      r_instr0        <= '0;
      r_pc0           <= '0;
      r_instr1        <= '0;
      r_pc1           <= '0;
    end else begin
      r_run           <= 1'b1;
      r_inflight_kill <= redirect_valid;
      r_inflight      <= w_req;
      if (w_req) begin
        r_pc          <= r_pc + ADDR_W'(4);
        r_inflight_pc <= r_pc;
      end
      if (redirect_valid) begin
        r_pc    <= {redirect_pc[ADDR_W-1:2], 2'b00};
        r_count <= 2'd0;
      end else begin
        if (w_pop) begin
          r_instr0 <= r_instr1;
          r_pc0    <= r_pc1;
        end
        // This write comes after the shift, so it overrides the shift when
        // the pop empties entry 0.
        if (w_push) begin
          if (w_slot == 2'd0) begin
            r_instr0 <= imem_rdata;
            r_pc0    <= r_inflight_pc;
          end else begin
            r_instr1 <= imem_rdata;
            r_pc1    <= r_inflight_pc;
          end
        end
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
    end
  end

`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of cycles in which decode holds off a valid head.
  // A redirect does not clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (if_valid && !id_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cnt;
`else
  // This build has no stall counter.
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the single-issue MIPS pipeline and the producer side of the opcode interface into the control decoder.
- Holds the PC and issues word reads to a synchronous instruction memory with fixed 1-cycle read latency.
- Buffers returned instructions in a 2-entry queue and presents instruction, opcode and PC to decode under a valid/ready handshake.
- Handles redirects from branch resolution by discarding stale fetches.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- ADDR_W, 32: PC and imem address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  read request this cycle.
- imem_addr  out  ADDR_W  byte address of request; always word-aligned.
- imem_rdata  in  32  read data, valid exactly 1 cycle after an imem_req.
- if_valid  out  1  head of queue holds a valid instruction.
- if_instr  out  32  head instruction.
- if_opcode  out  6  if_instr[31:26], feeds control decoder.
- if_pc  out  ADDR_W  address of head instruction.
- id_ready  in  1  decode accepts head when if_valid && id_ready.
- redirect_valid  in  1  branch/jump taken; flush and restart.
- redirect_pc  in  ADDR_W  restart address; bits [1:0] ignored and forced to 0.

Behaviour:
- Reset (async assert, sync release) clears the following state:
  - pc_q = RESET_PC
  - queue empty, count 0
  - inflight = 0, inflight_kill = 0
  - imem_req = 0
  - if_valid = 0; if_instr, if_pc = 0
- Request rule: imem_req = !redirect_valid && (count + inflight - pop) < 2, where pop = if_valid && id_ready. This is combinational.
  - imem_addr = pc_q.
  - On an issued request: pc_q <= pc_q + 4, wrapping modulo 2^ADDR_W. inflight <= 1 and records the issue PC.
  - Otherwise inflight <= 0.
- Response: in the cycle after a request, imem_rdata and the recorded PC are pushed to the queue tail, unless inflight_kill is set.
  - Push and pop in the same cycle are legal at any count.
  - The request rule guarantees no overflow; the queue never exceeds 2 entries.
- Head output is registered from the queue storage, with no combinational path from imem_rdata. Minimum latency from imem_req to if_valid is 2 cycles.
- Redirect (redirect_valid = 1), taking priority over everything:
  - Queue cleared; if_valid = 0 from the next cycle. A pop in the redirect cycle is still counted as accepted by decode.
  - Any request issued in the previous cycle is marked inflight_kill, and its data is dropped.
  - pc_q <= {redirect_pc[ADDR_W-1:2], 2'b00}. No request in the redirect cycle.
  - First request at the new PC is issued the following cycle.
  - Back-to-back redirects: the last one wins; each one suppresses requests in its own cycle.
- Stall: with id_ready = 0, the head holds stable (if_instr, if_pc, if_valid unchanged) and the queue fills to 2. Requests then stop; no instruction is lost or duplicated.
- Decode sees instructions in strict PC order between redirects.
- Reset asserted mid-operation abandons any in-flight read; its data is never pushed.

Optional Feature:
- Macro: IFETCH_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cycles (out, 32): counts cycles with if_valid && !id_ready.
  - Saturates at 32'hFFFF_FFFF, resets to 0, and is not cleared by redirect.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, id_ready = 1, imem returns word = addr:
  - imem_addr sequence 0x0, 0x4, 0x8 on consecutive cycles.
  - if_valid first high 2 cycles after the first req, with if_pc 0x0, 0x4, 0x8 and one instruction per cycle.
- Hold id_ready = 0 from the start:
  - Exactly 2 requests are issued (0x0, 0x4), then imem_req = 0.
  - if_pc holds 0x0.
  - Releasing id_ready delivers 0x0, 0x4, 0x8 with no gaps or duplicates.
- Redirect to 0x0000_0103 the cycle after the req to 0x8:
  - Data for 0x8 is dropped and the queue is flushed.
  - No req in the redirect cycle; the next req is to 0x100.
  - The next if_pc seen is 0x100.
- Two consecutive redirects, to 0x200 then 0x300: the only instructions delivered afterwards start at 0x300.
- pc_q = 0xFFFF_FFFC with ADDR_W = 32: the next request wraps to 0x0.
- IFETCH_STALL_CNT_EN defined, 5 cycles of if_valid && !id_ready: stall_cycles = 5.
- Assert rst_n low while a req is in flight: all outputs return to reset values immediately, and the dropped data never appears on if_instr.
